// File: rtl/wisc_pkg.sv
// Shared decode-stage definitions.
//   DATA_W      datapath / instruction / PC width
//   SEL_W       register-select width (8 GPRs)
//   NOP_INSTR   canonical no-operation encoding
//   sb_entry_t  scoreboard slot: {vld, sel} of an in-flight register write
//   sb_ctrl_t   scoreboard update command
//   stage_act_t per-cycle action chosen by the decode-stage priority logic
package wisc_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;

    localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic             vld;
        logic [SEL_W-1:0] sel;
    } sb_entry_t;

    // SB_DRAIN shifts the pipe forward while inserting an invalid slot,
    // used for both bubbles and flushes.
    typedef enum logic [1:0] {
        SB_HOLD,
        SB_DRAIN,
        SB_ADVANCE
    } sb_ctrl_t;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_ISSUE
    } stage_act_t;

    function automatic logic sb_hit(input sb_entry_t e, input logic [SEL_W-1:0] r);
        return e.vld && (e.sel == r);
    endfunction

endpackage

// File: rtl/id_hazard_stage_if.sv
// Decode-stage bus bundle.
//   Fetch side : if_valid, if_instr, if_pc in; if_stall out
//   Decoder    : id_instr out; dec_use_rs, dec_use_rt, dec_wen, dec_wsel in
//   rf_bypass  : read1regsel, read2regsel out; read1data, read2data in
//   Execute    : ex_stall, flush in; ex_valid, ex_pc, ex_instr, ex_rdata1,
//                ex_rdata2, ex_wen, ex_wsel out
// Modport slave is the decode stage itself; master is its environment.
interface id_hazard_stage_if;
    import wisc_pkg::*;

    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [DATA_W-1:0] if_pc;
    logic              if_stall;

    logic              dec_use_rs;
    logic              dec_use_rt;
    logic              dec_wen;
    logic [SEL_W-1:0]  dec_wsel;
    logic [DATA_W-1:0] id_instr;

    logic [SEL_W-1:0]  read1regsel;
    logic [SEL_W-1:0]  read2regsel;
    logic [DATA_W-1:0] read1data;
    logic [DATA_W-1:0] read2data;

    logic              ex_stall;
    logic              flush;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_instr;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic              ex_wen;
    logic [SEL_W-1:0]  ex_wsel;

    modport slave (
        input  if_valid, if_instr, if_pc,
        output if_stall,
        input  dec_use_rs, dec_use_rt, dec_wen, dec_wsel,
        output id_instr,
        output read1regsel, read2regsel,
        input  read1data, read2data,
        input  ex_stall, flush,
        output ex_valid, ex_pc, ex_instr, ex_rdata1, ex_rdata2, ex_wen, ex_wsel
    );

    modport master (
        output if_valid, if_instr, if_pc,
        input  if_stall,
        output dec_use_rs, dec_use_rt, dec_wen, dec_wsel,
        input  id_instr,
        input  read1regsel, read2regsel,
        output read1data, read2data,
        output ex_stall, flush,
        input  ex_valid, ex_pc, ex_instr, ex_rdata1, ex_rdata2, ex_wen, ex_wsel
    );

endinterface

// File: rtl/id_scoreboard.sv
// Two-entry write scoreboard tracking register producers in EX and MEM.
//   clk, rst   clock / synchronous active-low reset
//   i_ctrl     hold, drain (shift + insert invalid) or advance (shift + insert i_ins)
//   i_ins      entry entering the EX slot on advance
//   i_rs, i_rt source selects of the instruction in decode
//   o_hit_rs   i_rs matches a valid EX or MEM producer
//   o_hit_rt   i_rt matches a valid EX or MEM producer
module id_scoreboard
    import wisc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  sb_ctrl_t         i_ctrl,
    input  sb_entry_t        i_ins,
    input  logic [SEL_W-1:0] i_rs,
    input  logic [SEL_W-1:0] i_rt,
    output logic             o_hit_rs,
    output logic             o_hit_rt
);

    sb_entry_t r_sb_ex;
    sb_entry_t r_sb_mem;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sb_ex  <= '0;
            r_sb_mem <= '0;
        end else begin
            case (i_ctrl)
                SB_DRAIN: begin
                    r_sb_mem <= r_sb_ex;
                    r_sb_ex  <= '0;
                end
                SB_ADVANCE: begin
                    r_sb_mem <= r_sb_ex;
                    r_sb_ex  <= i_ins;
                end
                default: begin
                end
            endcase
        end
    end

    // WB producers are deliberately absent: rf_bypass forwards them.
    assign o_hit_rs = sb_hit(r_sb_ex, i_rs) | sb_hit(r_sb_mem, i_rs);
    assign o_hit_rt = sb_hit(r_sb_ex, i_rt) | sb_hit(r_sb_mem, i_rt);

endmodule

// File: rtl/id_hazard_stage.sv
// Decode stage: IF/ID register, register-file read selects, RAW hazard
// detection against EX/MEM producers, and the ID/EX register.
//   clk, rst   clock / synchronous active-low reset
//   bus        id_hazard_stage_if.slave (fetch, decoder, rf_bypass, execute)
//   stall_cnt  saturating count of hazard-stall cycles
// Per-cycle priority: ex_stall (freeze) > flush > hazard (bubble) > issue.
module id_hazard_stage
    import wisc_pkg::*;
#(
    parameter int SCNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    id_hazard_stage_if.slave   bus,
    output logic [SCNT_W-1:0]  stall_cnt
);

    logic              r_id_valid;
    logic [DATA_W-1:0] r_id_instr;
    logic [DATA_W-1:0] r_id_pc;

    logic              r_ex_valid;
    logic              r_ex_wen;
    logic [DATA_W-1:0] r_ex_pc;
    logic [DATA_W-1:0] r_ex_instr;
    logic [DATA_W-1:0] r_ex_rdata1;
    logic [DATA_W-1:0] r_ex_rdata2;
    logic [SEL_W-1:0]  r_ex_wsel;

    logic [SCNT_W-1:0] r_stall_cnt;

    logic [SEL_W-1:0]  w_rs;
    logic [SEL_W-1:0]  w_rt;
    logic              w_hit_rs;
    logic              w_hit_rt;
    logic              w_hazard;
    stage_act_t        w_act;
    sb_ctrl_t          w_sb_ctrl;
    sb_entry_t         w_sb_ins;

    assign w_rs = r_id_instr[10:8];
    assign w_rt = r_id_instr[7:5];

    assign w_hazard = r_id_valid & ((bus.dec_use_rs & w_hit_rs) |
                                    (bus.dec_use_rt & w_hit_rt));

    always_comb begin
        w_act = ACT_ISSUE;
        if (bus.ex_stall)
            w_act = ACT_HOLD;
        else if (bus.flush)
            w_act = ACT_FLUSH;
        else if (w_hazard)
            w_act = ACT_BUBBLE;
    end

    always_comb begin
        w_sb_ctrl = SB_ADVANCE;
        case (w_act)
            ACT_HOLD:               w_sb_ctrl = SB_HOLD;
            ACT_FLUSH, ACT_BUBBLE:  w_sb_ctrl = SB_DRAIN;
            default:                w_sb_ctrl = SB_ADVANCE;
        endcase
    end

    assign w_sb_ins.vld = r_id_valid & bus.dec_wen;
    assign w_sb_ins.sel = bus.dec_wsel;

    id_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .i_ctrl   (w_sb_ctrl),
        .i_ins    (w_sb_ins),
        .i_rs     (w_rs),
        .i_rt     (w_rt),
        .o_hit_rs (w_hit_rs),
        .o_hit_rt (w_hit_rt)
    );

    // IF/ID: a flush only invalidates; the redirected fetch arrives later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
            r_id_pc    <= '0;
        end else begin
            case (w_act)
                ACT_FLUSH: r_id_valid <= 1'b0;
                ACT_ISSUE: begin
                    r_id_valid <= bus.if_valid;
                    r_id_instr <= bus.if_instr;
                    r_id_pc    <= bus.if_pc;
                end
                default: begin
                end
            endcase
        end
    end

    // ID/EX: bubbles clear valid/wen and keep the stale payload.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_wen    <= 1'b0;
            r_ex_pc     <= '0;
            r_ex_instr  <= '0;
            r_ex_rdata1 <= '0;
            r_ex_rdata2 <= '0;
            r_ex_wsel   <= '0;
        end else begin
            case (w_act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    r_ex_valid <= 1'b0;
                    r_ex_wen   <= 1'b0;
                end
                ACT_ISSUE: begin
                    r_ex_valid  <= r_id_valid;
                    r_ex_wen    <= r_id_valid & bus.dec_wen;
                    r_ex_pc     <= r_id_pc;
                    r_ex_instr  <= r_id_instr;
                    r_ex_rdata1 <= bus.read1data;
                    r_ex_rdata2 <= bus.read2data;
                    r_ex_wsel   <= bus.dec_wsel;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (w_act == ACT_BUBBLE && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign bus.if_stall    = w_hazard | bus.ex_stall;
    assign bus.id_instr    = r_id_instr;
    assign bus.read1regsel = w_rs;
    assign bus.read2regsel = w_rt;
    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_wen      = r_ex_wen;
    assign bus.ex_pc       = r_ex_pc;
    assign bus.ex_instr    = r_ex_instr;
    assign bus.ex_rdata1   = r_ex_rdata1;
    assign bus.ex_rdata2   = r_ex_rdata2;
    assign bus.ex_wsel     = r_ex_wsel;
    assign stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Bench for id_hazard_stage: per-cycle expectation tables driven through a
// small in-order fetch model, plus a narrow-counter instance for saturation.
module tb_id_hazard_stage;
    import wisc_pkg::*;

    logic clk;
    logic rst;
    logic srst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction format used by the bench's decoder model:
    // [15] wen, [14] use_rs, [13:11] wsel, [10:8] rs, [7:5] rt, [4] use_rt
    function automatic logic [15:0] mk(input logic wen, input logic [2:0] wsel,
                                       input logic urs, input logic [2:0] rs,
                                       input logic urt, input logic [2:0] rt);
        return {wen, urs, wsel, rs, rt, urt, 4'h0};
    endfunction

    id_hazard_stage_if ifc ();
    id_hazard_stage_if sifc ();
    logic [15:0] stall_cnt;
    logic [3:0]  s_cnt;

    id_hazard_stage #(.SCNT_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (ifc.slave),
        .stall_cnt (stall_cnt)
    );

    id_hazard_stage #(.SCNT_W(4)) u_sat (
        .clk       (clk),
        .rst       (srst),
        .bus       (sifc.slave),
        .stall_cnt (s_cnt)
    );

    logic [15:0] rf [8];

    assign ifc.dec_wen    = ifc.id_instr[15];
    assign ifc.dec_use_rs = ifc.id_instr[14];
    assign ifc.dec_wsel   = ifc.id_instr[13:11];
    assign ifc.dec_use_rt = ifc.id_instr[4];
    assign ifc.read1data  = rf[ifc.read1regsel];
    assign ifc.read2data  = rf[ifc.read2regsel];

    // Saturation instance: endless chain of R1 <- f(R1).
    assign sifc.dec_wen    = sifc.id_instr[15];
    assign sifc.dec_use_rs = sifc.id_instr[14];
    assign sifc.dec_wsel   = sifc.id_instr[13:11];
    assign sifc.dec_use_rt = sifc.id_instr[4];
    assign sifc.read1data  = '0;
    assign sifc.read2data  = '0;
    assign sifc.ex_stall   = 1'b0;
    assign sifc.flush      = 1'b0;
    assign sifc.if_valid   = 1'b1;
    assign sifc.if_instr   = mk(1'b1, 3'd1, 1'b1, 3'd1, 1'b0, 3'd0);
    assign sifc.if_pc      = '0;

    typedef struct {
        logic        fl;
        logic        xs;
        logic        e_stall;
        logic        e_vld;
        logic [15:0] e_pc;
        logic        e_wen;
        logic [2:0]  e_wsel;
        logic [15:0] e_cnt;
        logic        wb;
        logic [2:0]  wb_sel;
        logic [15:0] wb_val;
        logic        chk_rd;
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
    } vec_t;

    vec_t        vq [$];
    logic [15:0] prog [$];
    int unsigned idx;
    int          total;
    int          bad;

    function automatic vec_t V(input logic fl, input logic xs, input logic st,
                               input logic vld, input logic [15:0] pc,
                               input logic wen, input logic [2:0] wsel,
                               input logic [15:0] cnt);
        vec_t v;
        v.fl = fl;        v.xs = xs;        v.e_stall = st;
        v.e_vld = vld;    v.e_pc = pc;      v.e_wen = wen;
        v.e_wsel = wsel;  v.e_cnt = cnt;
        v.wb = 1'b0;      v.wb_sel = '0;    v.wb_val = '0;
        v.chk_rd = 1'b0;  v.e_rd1 = '0;     v.e_rd2 = '0;
        return v;
    endfunction

    function automatic vec_t WB(input vec_t vi, input logic [2:0] s, input logic [15:0] val);
        vec_t v = vi;
        v.wb = 1'b1; v.wb_sel = s; v.wb_val = val;
        return v;
    endfunction

    function automatic vec_t RD(input vec_t vi, input logic [15:0] d1, input logic [15:0] d2);
        vec_t v = vi;
        v.chk_rd = 1'b1; v.e_rd1 = d1; v.e_rd2 = d2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic present();
        if (idx < prog.size()) begin
            ifc.if_valid = 1'b1;
            ifc.if_instr = prog[idx];
        end else begin
            ifc.if_valid = 1'b0;
            ifc.if_instr = '0;
        end
        ifc.if_pc = 16'(idx);
    endtask

    task automatic init_rf();
        for (int unsigned i = 0; i < 8; i++)
            rf[i] = 16'h0011 + 16'(i) * 16'h0100;
    endtask

    // Entered and left at a negedge; rst stays low for two posedges.
    task automatic do_reset(input string tn);
        init_rf();
        rst          = 1'b0;
        idx          = 0;
        ifc.flush    = 1'b0;
        ifc.ex_stall = 1'b0;
        present();
        repeat (2) @(posedge clk);
        #1;
        chk({tn, " rst ex_valid"}, 32'(ifc.ex_valid), 32'd0);
        chk({tn, " rst ex_wen"},   32'(ifc.ex_wen),   32'd0);
        chk({tn, " rst stall_cnt"}, 32'(stall_cnt),   32'd0);
        chk({tn, " rst if_stall"}, 32'(ifc.if_stall), 32'd0);
        chk({tn, " rst id_instr"}, 32'(ifc.id_instr), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        vq.delete();
    endtask

    task automatic run_vectors(input string tn);
        logic  st;
        string p;
        for (int unsigned i = 0; i < vq.size(); i++) begin
            ifc.flush    = vq[i].fl;
            ifc.ex_stall = vq[i].xs;
            #4;
            st = ifc.if_stall;
            @(posedge clk);
            #1;
            if (!st) idx++;
            present();
            if (vq[i].wb) rf[vq[i].wb_sel] = vq[i].wb_val;
            p = $sformatf("%s e%0d", tn, i + 1);
            chk({p, " if_stall"},  32'(ifc.if_stall), 32'(vq[i].e_stall));
            chk({p, " ex_valid"},  32'(ifc.ex_valid), 32'(vq[i].e_vld));
            chk({p, " ex_wen"},    32'(ifc.ex_wen),   32'(vq[i].e_wen));
            chk({p, " stall_cnt"}, 32'(stall_cnt),    32'(vq[i].e_cnt));
            if (vq[i].e_vld) begin
                chk({p, " ex_pc"},    32'(ifc.ex_pc),    32'(vq[i].e_pc));
                chk({p, " ex_wsel"},  32'(ifc.ex_wsel),  32'(vq[i].e_wsel));
                chk({p, " ex_instr"}, 32'(ifc.ex_instr), 32'(prog[vq[i].e_pc]));
            end
            if (vq[i].chk_rd) begin
                chk({p, " ex_rdata1"}, 32'(ifc.ex_rdata1), 32'(vq[i].e_rd1));
                chk({p, " ex_rdata2"}, 32'(ifc.ex_rdata2), 32'(vq[i].e_rd2));
            end
            @(negedge clk);
        end
        ifc.flush    = 1'b0;
        ifc.ex_stall = 1'b0;
    endtask

    task automatic load_raw_prog();
        prog.delete();
        prog.push_back(mk(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0));
        prog.push_back(mk(1'b1, 3'd4, 1'b1, 3'd3, 1'b0, 3'd0));
        prog.push_back(mk(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        srst  = 1'b0;

        // Back-to-back RAW through rs: two bubbles, then forwarded data.
        load_raw_prog();
        do_reset("t2");
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 1, 0, 1, 3, 0));
        vq.push_back(V(0, 0, 1, 0, 0, 0, 0, 1));
        vq.push_back(WB(V(0, 0, 0, 0, 0, 0, 0, 2), 3'd3, 16'hBEEF));
        vq.push_back(RD(V(0, 0, 0, 1, 1, 1, 4, 2), 16'hBEEF, 16'h0011));
        vq.push_back(V(0, 0, 0, 1, 2, 0, 0, 2));
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 2));
        run_vectors("t2");

        // Distance 2 (consumer via rt): one bubble.
        prog.delete();
        prog.push_back(mk(1'b1, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0));
        prog.push_back(mk(1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 3'd0));
        prog.push_back(mk(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5));
        do_reset("t3a");
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 1, 0, 1, 5, 0));
        vq.push_back(V(0, 0, 1, 1, 1, 1, 6, 0));
        vq.push_back(WB(V(0, 0, 0, 0, 0, 0, 0, 1), 3'd5, 16'h5A5A));
        vq.push_back(RD(V(0, 0, 0, 1, 2, 0, 0, 1), 16'h0011, 16'h5A5A));
        run_vectors("t3a");

        // Distance 3: no bubble, value arrives via WB forwarding.
        prog.delete();
        prog.push_back(mk(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0));
        prog.push_back(mk(1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 3'd0));
        prog.push_back(mk(1'b1, 3'd7, 1'b0, 3'd0, 1'b0, 3'd0));
        prog.push_back(mk(1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0));
        do_reset("t3b");
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 1, 0, 1, 2, 0));
        vq.push_back(V(0, 0, 0, 1, 1, 1, 6, 0));
        vq.push_back(WB(V(0, 0, 0, 1, 2, 1, 7, 0), 3'd2, 16'h2222));
        vq.push_back(RD(V(0, 0, 0, 1, 3, 0, 0, 0), 16'h2222, 16'h0011));
        run_vectors("t3b");

        // ex_stall for 3 cycles in the middle of a hazard.
        load_raw_prog();
        do_reset("t4");
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 1, 0, 1, 3, 0));
        vq.push_back(V(0, 0, 1, 0, 0, 0, 0, 1));
        vq.push_back(V(0, 1, 1, 0, 0, 0, 0, 1));
        vq.push_back(V(0, 1, 1, 0, 0, 0, 0, 1));
        vq.push_back(V(0, 1, 1, 0, 0, 0, 0, 1));
        vq.push_back(WB(V(0, 0, 0, 0, 0, 0, 0, 2), 3'd3, 16'hC3C3));
        vq.push_back(RD(V(0, 0, 0, 1, 1, 1, 4, 2), 16'hC3C3, 16'h0011));
        vq.push_back(V(0, 0, 0, 1, 2, 0, 0, 2));
        run_vectors("t4");

        // Flush while the hazard is pending.
        load_raw_prog();
        do_reset("t5");
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 1, 0, 1, 3, 0));
        vq.push_back(V(1, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 1, 2, 0, 0, 0));
        run_vectors("t5");

        // rt matches an in-flight dest but is not used: no stall.
        prog.delete();
        prog.push_back(mk(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0));
        prog.push_back(mk(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3));
        do_reset("t6a");
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(0, 0, 0, 1, 0, 1, 3, 0));
        vq.push_back(V(0, 0, 0, 1, 1, 0, 0, 0));
        run_vectors("t6a");

        // R0 gets no special treatment.
        prog.delete();
        prog.push_back(mk(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0));
        prog.push_back(mk(1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0));
        do_reset("t6b");
        vq.push_back(V(0, 0, 0, 0, 0, 0, 0, 0));
        vq.push_back(V(0, 0, 1, 1, 0, 1, 0, 0));
        vq.push_back(V(0, 0, 1, 0, 0, 0, 0, 1));
        run_vectors("t6b");

        // Saturation on a 4-bit counter: chain stalls 2 of every 3 cycles,
        // so the count reaches 2k after edge 3k+1 and sticks at 4'hF.
        chk("sat rst cnt", 32'(s_cnt), 32'd0);
        @(negedge clk);
        srst = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("sat cnt e7", 32'(s_cnt), 32'd4);
        repeat (15) @(posedge clk);
        #1;
        chk("sat cnt e22", 32'(s_cnt), 32'd14);
        repeat (4) @(posedge clk);
        #1;
        chk("sat cnt e26", 32'(s_cnt), 32'd15);
        repeat (24) @(posedge clk);
        #1;
        chk("sat cnt e50", 32'(s_cnt), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
